// File: rtl/usb_packet_tx_pkg.sv
// Shared definitions for the USB packet transmit stage: packet geometry and
// the byte-serialiser FSM state encoding.
package usb_packet_tx_pkg;

  localparam int unsigned PACKET_W         = 32;
  localparam int unsigned BYTES_PER_PACKET = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } tx_state_e;

endpackage

// File: rtl/usb_packet_tx_fifo.sv
// Single-clock packet FIFO with extra-MSB pointers and a registered
// (block-RAM style) read port: dout is valid the cycle after pop.
module packet_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] FULL_XOR = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [WIDTH-1:0]      rd_data_q;
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic                  do_push, do_pop;

  assign full    = (wr_ptr_q ^ rd_ptr_q) == FULL_XOR;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign dout    = rd_data_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
    if (do_pop)  rd_data_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

endmodule

// File: rtl/usb_packet_tx.sv
// Buffers 32-bit trace packets and serialises them MSB-first onto an
// FT245-style USB FIFO write interface, counting packets dropped on full.
module usb_packet_tx
  import usb_packet_tx_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2    = 9,
  parameter int unsigned WR_LOW_CYCLES = 2,
  parameter int unsigned DROP_CNT_W    = 16
) (
  input  logic                   mclk,
  input  logic                   reset_n,
  input  logic [31:0]            packet_data,
  input  logic                   packet_strobe,
  input  logic                   usb_txe_n,
  output logic                   usb_wr_n,
  output logic [7:0]             usb_d_out,
  output logic                   usb_d_oe,
  output logic [DEPTH_LOG2:0]    fifo_level,
  output logic [DROP_CNT_W-1:0]  drop_count,
  input  logic                   drop_clear
);

  localparam logic [3:0] WR_LAST   = 4'(WR_LOW_CYCLES - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PACKET - 1);
  localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  logic                  txe_meta_q, txe_s_q;
  tx_state_e             state_q, state_d;
  logic [PACKET_W-1:0]   sr_q, sr_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [3:0]            wr_cnt_q, wr_cnt_d;
  logic                  load_q, load_d;
  logic                  usb_wr_n_q, usb_wr_n_d;
  logic                  usb_d_oe_q, usb_d_oe_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;

  logic                  fifo_full, fifo_empty, fifo_pop;
  logic [PACKET_W-1:0]   fifo_dout;

  packet_fifo #(
    .WIDTH      (PACKET_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk   (mclk),
    .rst_n (reset_n),
    .push  (packet_strobe && !fifo_full),
    .din   (packet_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;
  assign usb_wr_n   = usb_wr_n_q;
  assign usb_d_oe   = usb_d_oe_q;
  assign usb_d_out  = sr_q[31:24];
  assign drop_count = drop_q;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      txe_meta_q <= 1'b1;
      txe_s_q    <= 1'b1;
    end else begin
      txe_meta_q <= usb_txe_n;
      txe_s_q    <= txe_meta_q;
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (drop_clear)
      drop_d = '0;
    else if (packet_strobe && fifo_full && (drop_q != DROP_MAX))
      drop_d = drop_q + DROP_ONE;
  end

  // The RAM read issued in IDLE lands in fifo_dout one cycle later, so the
  // first WAIT cycle (load_q set) copies it into sr rather than shifting.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    byte_idx_d = byte_idx_q;
    wr_cnt_d   = wr_cnt_q;
    load_d     = load_q;
    usb_wr_n_d = usb_wr_n_q;
    usb_d_oe_d = usb_d_oe_q;
    unique case (state_q)
      ST_IDLE: begin
        usb_wr_n_d = 1'b1;
        usb_d_oe_d = 1'b0;
        if (!fifo_empty) begin
          state_d    = ST_WAIT;
          load_d     = 1'b1;
          byte_idx_d = '0;
          usb_d_oe_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (load_q) begin
          sr_d   = fifo_dout;
          load_d = 1'b0;
        end
        if (!txe_s_q) begin
          state_d    = ST_STROBE;
          usb_wr_n_d = 1'b0;
          wr_cnt_d   = '0;
        end
      end
      ST_STROBE: begin
        if (wr_cnt_q == WR_LAST) begin
          state_d    = ST_HOLD;
          usb_wr_n_d = 1'b1;
        end else begin
          wr_cnt_d = wr_cnt_q + 4'd1;
        end
      end
      ST_HOLD: begin
        sr_d       = {sr_q[23:0], 8'h00};
        byte_idx_d = byte_idx_q + 2'd1;
        if (byte_idx_q == LAST_BYTE) begin
          state_d    = ST_IDLE;
          usb_d_oe_d = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      byte_idx_q <= '0;
      wr_cnt_q   <= '0;
      load_q     <= 1'b0;
      usb_wr_n_q <= 1'b1;
      usb_d_oe_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      byte_idx_q <= byte_idx_d;
      wr_cnt_q   <= wr_cnt_d;
      load_q     <= load_d;
      usb_wr_n_q <= usb_wr_n_d;
      usb_d_oe_q <= usb_d_oe_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_usb_packet_tx.sv
// Scoreboard bench for usb_packet_tx: stimulus queues expected bytes, a
// monitor pops and compares on every usb_wr_n rising edge.
module tb_usb_packet_tx;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] packet_data = '0;
  logic        packet_strobe = 1'b0;
  logic        usb_txe_n = 1'b0;
  logic        drop_clear = 1'b0;
  logic        usb_wr_n;
  logic [7:0]  usb_d_out;
  logic        usb_d_oe;
  logic [9:0]  fifo_level;
  logic [15:0] drop_count;

  usb_packet_tx #(
    .DEPTH_LOG2    (9),
    .WR_LOW_CYCLES (2),
    .DROP_CNT_W    (16)
  ) dut (
    .mclk          (mclk),
    .reset_n       (reset_n),
    .packet_data   (packet_data),
    .packet_strobe (packet_strobe),
    .usb_txe_n     (usb_txe_n),
    .usb_wr_n      (usb_wr_n),
    .usb_d_out     (usb_d_out),
    .usb_d_oe      (usb_d_oe),
    .fifo_level    (fifo_level),
    .drop_count    (drop_count),
    .drop_clear    (drop_clear)
  );

  always #5 mclk = ~mclk;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;
  int          rise_cnt = 0;
  logic [7:0]  exp_q[$];
  int unsigned rise_cyc[$];

  always @(posedge mclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge mclk);
    #1;
  endtask

  task automatic expect_pkt(input logic [31:0] d);
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
  endtask

  task automatic push_pkt(input logic [31:0] d);
    packet_data   = d;
    packet_strobe = 1'b1;
    tick();
    packet_strobe = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || usb_d_oe !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  // Monitor: a byte is latched by the host on each usb_wr_n rising edge.
  initial begin : monitor
    logic prev_wr;
    prev_wr = 1'b1;
    forever begin
      @(negedge mclk);
      if (!reset_n) begin
        prev_wr = 1'b1;
      end else begin
        if (prev_wr == 1'b0 && usb_wr_n == 1'b1) begin
          rise_cnt++;
          rise_cyc.push_back(cyc);
          check("byte_oe", 32'(usb_d_oe), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got %0h expected none", usb_d_out);
          end else begin
            check("byte", 32'(usb_d_out), 32'(exp_q.pop_front()));
          end
        end
        prev_wr = usb_wr_n;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   n;
    int   falls;
    logic pw;
    logic stall_ok;
    int   maxl;

    // Reset state
    reset_n = 1'b0;
    usb_txe_n = 1'b0;
    repeat (3) tick();
    check("rst_wr_n", 32'(usb_wr_n), 32'd1);
    check("rst_oe", 32'(usb_d_oe), 32'd0);
    check("rst_dout", 32'(usb_d_out), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    reset_n = 1'b1;
    repeat (4) tick();

    // Single packet, latency and byte period
    rise_cnt = 0;
    rise_cyc.delete();
    expect_pkt(32'hA1B2C3D4);
    push_pkt(32'hA1B2C3D4);
    check("lat_idle_wr_n", 32'(usb_wr_n), 32'd1);
    check("lat_idle_oe", 32'(usb_d_oe), 32'd0);
    tick();
    check("lat_wait_oe", 32'(usb_d_oe), 32'd1);
    check("lat_wait_wr_n", 32'(usb_wr_n), 32'd1);
    tick();
    check("lat_fall_wr_n", 32'(usb_wr_n), 32'd0);
    check("lat_fall_data", 32'(usb_d_out), 32'hA1);
    n = 0;
    while (rise_cnt < 4 && n < 40) begin
      tick();
      n++;
    end
    check("t1_bytes", 32'(rise_cnt), 32'd4);
    check("t1_oe_off", 32'(usb_d_oe), 32'd0);
    if (rise_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check("t1_period", rise_cyc[i] - rise_cyc[i-1], 32'd4);
    end

    // Backpressure after byte 2
    rise_cnt = 0;
    expect_pkt(32'h00000001);
    push_pkt(32'h00000001);
    falls = 0;
    pw = usb_wr_n;
    n = 0;
    while (falls < 2 && n < 100) begin
      tick();
      n++;
      if (pw && !usb_wr_n) falls++;
      pw = usb_wr_n;
    end
    check("t2_second_fall", 32'(falls), 32'd2);
    usb_txe_n = 1'b1;
    stall_ok = 1'b1;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (k >= 6 && (usb_wr_n !== 1'b1 || usb_d_out !== 8'h00 || usb_d_oe !== 1'b1))
        stall_ok = 1'b0;
    end
    check("t2_stall_stable", 32'(stall_ok), 32'd1);
    check("t2_stall_bytes", 32'(rise_cnt), 32'd2);
    usb_txe_n = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (usb_wr_n && n < 20);
    check("t2_resume_cycles", 32'(n), 32'd3);
    wait_drain("t2_drain", 100);

    // Overflow: the first packet is popped into sr, so 513 are accepted
    usb_txe_n = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < 516; i++) begin
      packet_data = 32'h1000_0000 + 32'(i);
      if (i < 513) expect_pkt(packet_data);
      packet_strobe = 1'b1;
      tick();
    end
    packet_strobe = 1'b0;
    tick();
    check("t3_level_full", 32'(fifo_level), 32'd512);
    check("t3_drop3", 32'(drop_count), 32'd3);

    // drop_clear against a concurrent drop
    push_pkt(32'hDEAD0001);
    push_pkt(32'hDEAD0002);
    check("t5_drop5", 32'(drop_count), 32'd5);
    packet_data   = 32'hDEAD0003;
    packet_strobe = 1'b1;
    drop_clear    = 1'b1;
    tick();
    packet_strobe = 1'b0;
    drop_clear    = 1'b0;
    check("t5_drop_cleared", 32'(drop_count), 32'd0);
    check("t5_level_kept", 32'(fifo_level), 32'd512);
    usb_txe_n = 1'b0;
    wait_drain("t3_drain", 20000);
    check("t3_level_empty", 32'(fifo_level), 32'd0);

    // Pointer wrap at one push per 20 cycles
    maxl = 0;
    for (int i = 0; i < 2000; i++) begin
      expect_pkt(32'hA500_0000 + 32'(i));
      push_pkt(32'hA500_0000 + 32'(i));
      if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
      repeat (19) begin
        tick();
        if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
      end
    end
    wait_drain("t4_drain", 200);
    check("t4_max_level", 32'(maxl), 32'd1);
    check("t4_drop", 32'(drop_count), 32'd0);

    // Reset during byte 2
    rise_cnt = 0;
    exp_q.push_back(8'h11);
    push_pkt(32'h11223344);
    n = 0;
    while (!(rise_cnt >= 1 && usb_wr_n == 1'b0) && n < 100) begin
      tick();
      n++;
    end
    check("t6_in_byte2", 32'(usb_wr_n), 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rst_wr_n", 32'(usb_wr_n), 32'd1);
    check("t6_rst_oe", 32'(usb_d_oe), 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (100) tick();
    check("t6_level", 32'(fifo_level), 32'd0);
    check("t6_oe_idle", 32'(usb_d_oe), 32'd0);
    check("t6_bytes", 32'(rise_cnt), 32'd1);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
